// File: rtl/enc_vel_counter.sv
// ---------------------------------------------------------------------------
// enc_vel_counter
//
// Quadrature count accumulator placed after the quadrature edge/direction
// decoder. It keeps a free-running wrapping position count and, once every
// PERIOD clocks, snapshots a saturating signed count of the window that just
// closed.
//
// Parameters:
//   PERIOD  clocks per velocity window (>= 2)
//   PW      position width (two's complement, wraps)
//   VW      velocity / window accumulator width (two's complement, saturates)
//
// Ports:
//   Clk       in   system clock, all state on the rising edge
//   reset     in   asynchronous active-high reset, clears all state
//   CntPulse  in   one-cycle count strobe from the decoder
//   CntDir    in   direction, 1 = +1, 0 = -1, used only while CntPulse = 1
//   PosClr    in   synchronous position clear (wins over a same-cycle pulse)
//   SatClr    in   synchronous clear of SatFlag (a same-cycle clamp wins)
//   Position  out  running signed position count (PW bits)
//   Velocity  out  signed count of the last completed window (VW bits)
//   VelValid  out  one-cycle strobe, Velocity was just updated
//   SatFlag   out  sticky, a window accumulator hit a rail
//
// Strobe semantics: CntPulse is a qualifier-free strobe; every cycle it is
// high is exactly one count, there is no ready/back-pressure. VelValid is a
// one-cycle strobe asserted in the cycle after each terminal cycle, and
// Velocity changes only in that same cycle.
// ---------------------------------------------------------------------------
module enc_vel_counter #(
    parameter int PERIOD = 50000,
    parameter int PW     = 32,
    parameter int VW     = 16
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          CntPulse,
    input  logic          CntDir,
    input  logic          PosClr,
    input  logic          SatClr,
    output logic [PW-1:0] Position,
    output logic [VW-1:0] Velocity,
    output logic          VelValid,
    output logic          SatFlag
);

    localparam int              CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(PERIOD - 1);
    localparam logic [VW-1:0]   ACC_MAX  = {1'b0, {(VW-1){1'b1}}};
    localparam logic [VW-1:0]   ACC_MIN  = {1'b1, {(VW-1){1'b0}}};

    logic [CW-1:0] cnt_q,   cnt_d;
    logic [PW-1:0] pos_q,   pos_d;
    logic [VW-1:0] acc_q,   acc_d;
    logic [VW-1:0] vel_q,   vel_d;
    logic          vv_q,    vv_d;
    logic          sat_q,   sat_d;

    logic          step_up;
    logic          step_dn;
    logic          terminal;
    logic          clamp;
    logic [VW-1:0] acc_step;

    always_comb begin
        step_up  = CntPulse & CntDir;
        step_dn  = CntPulse & ~CntDir;
        terminal = (cnt_q == CNT_LAST);

        // Period counter never stops; the terminal value wraps back to 0.
        cnt_d = terminal ? '0 : cnt_q + CW'(1);

        // Position wraps naturally through modular add/subtract.
        pos_d = pos_q;
        if (PosClr) begin
            pos_d = '0;
        end else if (step_up) begin
            pos_d = pos_q + PW'(1);
        end else if (step_dn) begin
            pos_d = pos_q - PW'(1);
        end

        // Steps are only +-1, so a clamp happens exactly when the
        // accumulator already sits on the rail it is stepping towards.
        clamp    = 1'b0;
        acc_step = acc_q;
        if (step_up) begin
            if (acc_q == ACC_MAX) begin
                clamp = 1'b1;
            end else begin
                acc_step = acc_q + VW'(1);
            end
        end else if (step_dn) begin
            if (acc_q == ACC_MIN) begin
                clamp = 1'b1;
            end else begin
                acc_step = acc_q - VW'(1);
            end
        end

        // A pulse in the terminal cycle belongs to the closing window.
        acc_d = terminal ? '0 : acc_step;
        vel_d = terminal ? acc_step : vel_q;
        vv_d  = terminal;

        // Set has priority over clear.
        sat_d = clamp | (sat_q & ~SatClr);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pos_q <= '0;
            acc_q <= '0;
            vel_q <= '0;
            vv_q  <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pos_q <= pos_d;
            acc_q <= acc_d;
            vel_q <= vel_d;
            vv_q  <= vv_d;
            sat_q <= sat_d;
        end
    end

    assign Position = pos_q;
    assign Velocity = vel_q;
    assign VelValid = vv_q;
    assign SatFlag  = sat_q;

endmodule

// File: tb/tb_enc_vel_counter.sv
// ---------------------------------------------------------------------------
// tb_enc_vel_counter
//
// Two instances share one clock and reset:
//   dut_a : PERIOD=10, PW=8, VW=8  (counting, windows, wrap, clear, stream)
//   dut_b : PERIOD=20, PW=8, VW=4  (saturation and SatFlag behaviour)
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too. `e` counts rising edges since the last reset release (edge 0 is the
// first one), so after tick() the last edge seen is e-1.
// ---------------------------------------------------------------------------
module tb_enc_vel_counter;

    logic       clk;
    logic       rst;

    logic       a_pulse, a_dir, a_pclr, a_sclr;
    logic [7:0] a_pos;
    logic [7:0] a_vel;
    logic       a_vv, a_sat;

    logic       b_pulse, b_dir, b_pclr, b_sclr;
    logic [7:0] b_pos;
    logic [3:0] b_vel;
    logic       b_vv, b_sat;

    int n_checks = 0;
    int n_err    = 0;
    int e        = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    enc_vel_counter #(.PERIOD(10), .PW(8), .VW(8)) dut_a (
        .Clk      (clk),
        .reset    (rst),
        .CntPulse (a_pulse),
        .CntDir   (a_dir),
        .PosClr   (a_pclr),
        .SatClr   (a_sclr),
        .Position (a_pos),
        .Velocity (a_vel),
        .VelValid (a_vv),
        .SatFlag  (a_sat)
    );

    enc_vel_counter #(.PERIOD(20), .PW(8), .VW(4)) dut_b (
        .Clk      (clk),
        .reset    (rst),
        .CntPulse (b_pulse),
        .CntDir   (b_dir),
        .PosClr   (b_pclr),
        .SatClr   (b_sclr),
        .Position (b_pos),
        .Velocity (b_vel),
        .VelValid (b_vv),
        .SatFlag  (b_sat)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_pos"}, 32'(a_pos), 32'h0);
        check({tag, "_a_vel"}, 32'(a_vel), 32'h0);
        check({tag, "_a_vv"},  32'(a_vv),  32'h0);
        check({tag, "_a_sat"}, 32'(a_sat), 32'h0);
        check({tag, "_b_pos"}, 32'(b_pos), 32'h0);
        check({tag, "_b_vel"}, 32'(b_vel), 32'h0);
        check({tag, "_b_vv"},  32'(b_vv),  32'h0);
        check({tag, "_b_sat"}, 32'(b_sat), 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        a_pulse = 1'b0; a_dir = 1'b0; a_pclr = 1'b0; a_sclr = 1'b0;
        b_pulse = 1'b0; b_dir = 1'b0; b_pclr = 1'b0; b_sclr = 1'b0;
        rst = 1'b1;
        #3;
        check_all_zero("por");

        @(posedge clk); #1;
        rst = 1'b0;
        e = 0;

        // A window 0 (edges 0..9): up pulses on edges 0..3
        a_pulse = 1'b1; a_dir = 1'b1;
        tick();                                        // e=1
        check("a_pos_latency1", 32'(a_pos), 32'd1);
        ticks(3);                                      // e=4
        a_pulse = 1'b0;
        check("a_pos_4up", 32'(a_pos), 32'd4);
        ticks(5);                                      // e=9
        check("a_vv_before_term", 32'(a_vv), 32'd0);
        check("a_vel_before_term", 32'(a_vel), 32'd0);
        tick();                                        // e=10
        check("a_vv_w0", 32'(a_vv), 32'd1);
        check("a_vel_w0", 32'(a_vel), 32'd4);
        tick();                                        // e=11
        check("a_vv_one_cycle", 32'(a_vv), 32'd0);
        check("a_vel_hold", 32'(a_vel), 32'd4);

        // A window 1 empty; B window 0 empty
        ticks(9);                                      // e=20
        check("a_vv_w1", 32'(a_vv), 32'd1);
        check("a_vel_w1_empty", 32'(a_vel), 32'd0);
        check("b_vv_w0", 32'(b_vv), 32'd1);
        check("b_vel_w0", 32'(b_vel), 32'd0);

        // A window 2: 3 up (20..22), 5 down (23..27). B: 10 up (20..29)
        a_pulse = 1'b1; a_dir = 1'b1;
        b_pulse = 1'b1; b_dir = 1'b1;
        ticks(3);                                      // e=23
        a_dir = 1'b0;
        ticks(4);                                      // e=27
        check("b_sat_before_clamp", 32'(b_sat), 32'd0);
        tick();                                        // e=28
        a_pulse = 1'b0;
        check("b_sat_on_clamp", 32'(b_sat), 32'd1);
        check("a_pos_mixed", 32'(a_pos), 32'd2);
        ticks(2);                                      // e=30
        b_pulse = 1'b0;
        check("a_vv_w2", 32'(a_vv), 32'd1);
        check("a_vel_mixed", 32'(a_vel), 32'hFE);

        // A window 3: single up pulse on the terminal edge 39
        ticks(9);                                      // e=39
        a_pulse = 1'b1; a_dir = 1'b1;
        tick();                                        // e=40
        a_pulse = 1'b0;
        check("a_vel_term_pulse", 32'(a_vel), 32'd1);
        check("a_pos_term_pulse", 32'(a_pos), 32'd3);
        check("b_vv_w1", 32'(b_vv), 32'd1);
        check("b_vel_pos_rail", 32'(b_vel), 32'h7);

        // B window 2: 10 down (40..49). A window 4 empty.
        b_pulse = 1'b1; b_dir = 1'b0;
        ticks(10);                                     // e=50
        b_pulse = 1'b0;
        check("a_vel_after_term_empty", 32'(a_vel), 32'd0);
        check("b_sat_sticky", 32'(b_sat), 32'd1);

        // A window 5: edge 50 PosClr + up, edge 51 down, edge 52 up.
        // B: SatClr alone on edge 50.
        a_pclr = 1'b1; a_pulse = 1'b1; a_dir = 1'b1;
        b_sclr = 1'b1;
        tick();                                        // e=51
        a_pclr = 1'b0; a_dir = 1'b0;
        b_sclr = 1'b0;
        check("a_pos_clr_wins", 32'(a_pos), 32'd0);
        check("b_satclr_alone", 32'(b_sat), 32'd0);
        tick();                                        // e=52
        a_dir = 1'b1;
        check("a_pos_wrap_down", 32'(a_pos), 32'hFF);
        tick();                                        // e=53
        a_pulse = 1'b0;
        check("a_pos_wrap_back", 32'(a_pos), 32'd0);
        ticks(7);                                      // e=60
        check("a_vel_counts_clr_pulse", 32'(a_vel), 32'd1);
        check("b_vv_w2", 32'(b_vv), 32'd1);
        check("b_vel_neg_rail", 32'(b_vel), 32'h8);
        check("b_pos_net0", 32'(b_pos), 32'd0);

        // A: continuous up stream on edges 60..187.
        // B: up on 60..67 with SatClr on the clamping edge 67, then down 68..70.
        a_pulse = 1'b1; a_dir = 1'b1;
        b_pulse = 1'b1; b_dir = 1'b1;
        tick();                                        // e=61
        check("a_stream_pos1", 32'(a_pos), 32'd1);
        tick();                                        // e=62
        check("a_stream_pos2", 32'(a_pos), 32'd2);
        ticks(5);                                      // e=67
        check("b_sat_before_set_wins", 32'(b_sat), 32'd0);
        b_sclr = 1'b1;
        tick();                                        // e=68
        b_sclr = 1'b0;
        b_dir  = 1'b0;
        check("b_set_beats_clr", 32'(b_sat), 32'd1);
        ticks(2);                                      // e=70
        check("a_stream_vv", 32'(a_vv), 32'd1);
        check("a_stream_vel", 32'(a_vel), 32'd10);
        tick();                                        // e=71
        b_pulse = 1'b0;
        check("b_pos_5", 32'(b_pos), 32'd5);
        ticks(9);                                      // e=80
        check("a_stream_vel2", 32'(a_vel), 32'd10);
        check("a_stream_pos20", 32'(a_pos), 32'd20);
        ticks(107);                                    // e=187
        check("a_pos_max_pos", 32'(a_pos), 32'h7F);
        tick();                                        // e=188
        a_pulse = 1'b0;
        check("a_pos_wrap_up", 32'(a_pos), 32'h80);
        ticks(2);                                      // e=190
        check("a_vel_partial", 32'(a_vel), 32'd8);
        check("b_pos_pre_reset", 32'(b_pos), 32'd5);
        check("b_sat_pre_reset", 32'(b_sat), 32'd1);

        // Mid-run asynchronous reset, checked before any clock edge.
        ticks(3);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        e = 0;
        ticks(9);                                      // e=9
        check("a_vv_not_early", 32'(a_vv), 32'd0);
        tick();                                        // e=10
        check("a_vv_restart", 32'(a_vv), 32'd1);
        check("a_vel_restart", 32'(a_vel), 32'd0);
        ticks(9);                                      // e=19
        check("b_vv_not_early", 32'(b_vv), 32'd0);
        tick();                                        // e=20
        check("b_vv_restart", 32'(b_vv), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
